// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
//   Shared AHB-Lite encodings for the bus arbiter:
//     htrans_t    - HTRANS transfer types
//     hburst_t    - HBURST burst types
//     arb_state_t - arbiter FSM states
//     burst_beats - beat count of a burst type (0 for undefined-length INCR)
// ---------------------------------------------------------------------------
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    BURST = 2'd1,
    LOCK  = 2'd2
  } arb_state_t;

  // Number of beats in a burst; INCR has no defined length and returns 0.
  function automatic logic [4:0] burst_beats(hburst_t burst);
    case (burst)
      HBURST_SINGLE:                return 5'd1;
      HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
      HBURST_WRAP16, HBURST_INCR16: return 5'd16;
      default:                      return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// ---------------------------------------------------------------------------
// ahb_arb_pick
//   Combinational request picker. The request vector is rotated so that the
//   pointer position becomes bit 0, the lowest set bit is found, and the
//   offset is added back to the pointer modulo MAS_NUMBER.
//   With ARB_MODE=0 the pointer is ignored (fixed priority, lowest index).
// Ports:
//   req_i   - per-master request vector
//   ptr_i   - round-robin search start
//   idx_o   - index of the winning master (meaningless when valid_o=0)
//   valid_o - at least one request is pending
// ---------------------------------------------------------------------------
module ahb_arb_pick #(
  parameter int MAS_NUMBER = 16,
  parameter int ARB_MODE   = 1
) (
  input  logic [MAS_NUMBER-1:0]         req_i,
  input  logic [$clog2(MAS_NUMBER)-1:0] ptr_i,
  output logic [$clog2(MAS_NUMBER)-1:0] idx_o,
  output logic                          valid_o
);

  localparam int IW = $clog2(MAS_NUMBER);

  logic [IW-1:0]           base;
  logic [2*MAS_NUMBER-1:0] dbl;
  logic [MAS_NUMBER-1:0]   rot;
  logic [IW-1:0]           off;
  logic [IW:0]             sum;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave a value unassigned and infer a latch.
  always_comb begin
    base = (ARB_MODE != 0) ? ptr_i : '0;
    dbl  = {req_i, req_i} >> base;
    rot  = dbl[MAS_NUMBER-1:0];
    off  = '0;
    // Descending scan so the lowest set bit is the last one written.
    for (int i = MAS_NUMBER - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum = {1'b0, off} + {1'b0, base};
    if (sum >= (IW + 1)'(MAS_NUMBER)) sum = sum - (IW + 1)'(MAS_NUMBER);
    idx_o = sum[IW-1:0];
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/ahb_arbiter_rr.sv
// ---------------------------------------------------------------------------
// ahb_arbiter_rr
//   AHB-Lite multi-master arbiter with round-robin or fixed priority, a
//   default master, grant hold over defined-length bursts and locked
//   sequences, and registered HMASTER/HMASTLOCK handover.
//   All state advances only on accepted transfers (hready_i=1).
// Ports:
//   clk_i, rst_n_i  - HCLK, HRESETn (asynchronous, active-low)
//   hbusreq_i       - per-master bus request
//   hlock_i         - per-master lock request
//   htrans_i        - HTRANS of the address-phase owner
//   hburst_i        - HBURST of the address-phase owner
//   hready_i        - shared HREADY
//   hgrant_o        - one-hot grant
//   hmaster_o       - index of the address-phase owner
//   hmastlock_o     - current address phase is locked
// ---------------------------------------------------------------------------
module ahb_arbiter_rr
  import ahb_pkg::*;
#(
  parameter int MAS_NUMBER = 16,
  parameter int DEF_MASTER = 0,
  parameter int ARB_MODE   = 1,
  parameter int BURST_HOLD = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [MAS_NUMBER-1:0]         hbusreq_i,
  input  logic [MAS_NUMBER-1:0]         hlock_i,
  input  logic [1:0]                    htrans_i,
  input  logic [2:0]                    hburst_i,
  input  logic                          hready_i,
  output logic [MAS_NUMBER-1:0]         hgrant_o,
  output logic [$clog2(MAS_NUMBER)-1:0] hmaster_o,
  output logic                          hmastlock_o
);

  localparam int IW = $clog2(MAS_NUMBER);
  localparam logic [MAS_NUMBER-1:0] DEF_GRANT =
    {{(MAS_NUMBER - 1){1'b0}}, 1'b1} << DEF_MASTER;

  arb_state_t            state, state_nxt;
  logic [IW-1:0]         rr_ptr, ptr_nxt;
  logic [3:0]            beat_cnt, cnt_nxt;
  logic [MAS_NUMBER-1:0] grant_nxt;
  logic [IW-1:0]         grant_idx;
  logic [IW-1:0]         pick_raw, pick_idx;
  logic                  pick_valid;
  logic                  rearb;
  logic [4:0]            beats;
  htrans_t               trans;

  assign trans = htrans_t'(htrans_i);

  ahb_arb_pick #(
    .MAS_NUMBER (MAS_NUMBER),
    .ARB_MODE   (ARB_MODE)
  ) u_pick (
    .req_i   (hbusreq_i),
    .ptr_i   (rr_ptr),
    .idx_o   (pick_raw),
    .valid_o (pick_valid)
  );

  assign pick_idx = pick_valid ? pick_raw : IW'(DEF_MASTER);

  // Grant is always one-hot, so a plain encoder gives its index.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < MAS_NUMBER; i++) begin
      if (hgrant_o[i]) grant_idx = IW'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = beat_cnt;
    rearb     = 1'b0;
    beats     = burst_beats(hburst_t'(hburst_i));
    case (state)
      ARB: begin
        // Lock wins over burst; in both cases the grant stays with the
        // master that is starting the sequence.
        if (trans == HTRANS_NONSEQ && hlock_i[grant_idx]) begin
          state_nxt = LOCK;
        end else if (BURST_HOLD != 0 && trans == HTRANS_NONSEQ && beats >= 5'd4) begin
          state_nxt = BURST;
          cnt_nxt   = 4'(beats - 5'd2);
        end else begin
          rearb = 1'b1;
        end
      end
      BURST: begin
        case (trans)
          HTRANS_SEQ: begin
            // Last beat: re-arbitrate now so the new grant overlaps it.
            if (beat_cnt == 4'd0) begin
              state_nxt = ARB;
              rearb     = 1'b1;
            end else begin
              cnt_nxt = beat_cnt - 4'd1;
            end
          end
          HTRANS_BUSY: ;
          default: begin
            // IDLE or NONSEQ terminates the burst early.
            state_nxt = ARB;
            cnt_nxt   = 4'd0;
            rearb     = 1'b1;
          end
        endcase
      end
      LOCK: begin
        if (!hlock_i[hmaster_o]) begin
          state_nxt = ARB;
          rearb     = 1'b1;
        end
      end
      default: state_nxt = ARB;
    endcase

    grant_nxt = hgrant_o;
    ptr_nxt   = rr_ptr;
    if (rearb) begin
      grant_nxt           = '0;
      grant_nxt[pick_idx] = 1'b1;
      // The pointer moves only when a real request won, not for the default.
      if (pick_valid) begin
        ptr_nxt = (pick_raw == IW'(MAS_NUMBER - 1)) ? '0 : pick_raw + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ARB;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      hgrant_o    <= DEF_GRANT;
      hmaster_o   <= IW'(DEF_MASTER);
      hmastlock_o <= 1'b0;
    end else if (hready_i) begin
      state       <= state_nxt;
      rr_ptr      <= ptr_nxt;
      beat_cnt    <= cnt_nxt;
      hgrant_o    <= grant_nxt;
      hmaster_o   <= grant_idx;
      hmastlock_o <= hlock_i[grant_idx];
    end
  end

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_ahb_arbiter_rr
//   Two 4-master arbiters driven by the same stimulus: a round-robin one
//   (default master 3) and a fixed-priority one (default master 2). A
//   behavioural model of both is compared against the outputs every cycle,
//   and directed sequences pin hand-computed values.
// ---------------------------------------------------------------------------
module tb_ahb_arbiter_rr;

  localparam int N      = 4;
  localparam int DEF_RR = 3;
  localparam int DEF_FP = 2;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_BUSY   = 2'd1;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;

  localparam logic [2:0] B_SINGLE = 3'd0;
  localparam logic [2:0] B_INCR4  = 3'd3;
  localparam logic [2:0] B_WRAP8  = 3'd4;
  localparam logic [2:0] B_INCR8  = 3'd5;
  localparam logic [2:0] B_INCR16 = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, lock;
  logic [1:0] trans;
  logic [2:0] burst;
  logic       ready;

  logic [3:0] grant_rr, grant_fp;
  logic [1:0] master_rr, master_fp;
  logic       mlock_rr, mlock_fp;

  ahb_arbiter_rr #(.MAS_NUMBER(N), .DEF_MASTER(DEF_RR), .ARB_MODE(1), .BURST_HOLD(1)) dut_rr (
    .clk_i(clk), .rst_n_i(rst_n), .hbusreq_i(req), .hlock_i(lock), .htrans_i(trans),
    .hburst_i(burst), .hready_i(ready), .hgrant_o(grant_rr), .hmaster_o(master_rr),
    .hmastlock_o(mlock_rr));

  ahb_arbiter_rr #(.MAS_NUMBER(N), .DEF_MASTER(DEF_FP), .ARB_MODE(0), .BURST_HOLD(1)) dut_fp (
    .clk_i(clk), .rst_n_i(rst_n), .hbusreq_i(req), .hlock_i(lock), .htrans_i(trans),
    .hburst_i(burst), .hready_i(ready), .hgrant_o(grant_fp), .hmaster_o(master_fp),
    .hmastlock_o(mlock_fp));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (index 0 = round-robin, 1 = fixed) ---
  int m_grant[2], m_master[2], m_mlock[2], m_ptr[2], m_seq_left[2];
  bit m_locked[2];

  function automatic int beats_of(input logic [2:0] b);
    case (b)
      3'd0:       return 1;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 0;
    endcase
  endfunction

  function automatic int model_pick(input int k, input logic [3:0] r);
    int p;
    if (r == 4'd0) return (k == 0) ? DEF_RR : DEF_FP;
    for (int j = N - 1; j >= 0; j--) begin
      p = (k == 0) ? (m_ptr[k] + j) % N : j;
      if (k == 1 && r[p]) model_pick = p;
    end
    if (k == 1) return model_pick;
    for (int j = 0; j < N; j++) begin
      p = (m_ptr[k] + j) % N;
      if (r[p]) return p;
    end
    return 0;
  endfunction

  task automatic model_reset(input int k);
    m_grant[k]    = (k == 0) ? DEF_RR : DEF_FP;
    m_master[k]   = m_grant[k];
    m_mlock[k]    = 0;
    m_ptr[k]      = 0;
    m_seq_left[k] = 0;
    m_locked[k]   = 1'b0;
  endtask

  // One accepted transfer: decide whether the owner keeps the bus, then
  // hand the address phase to whoever held the grant.
  task automatic model_step(input int k);
    int  p, owner;
    bit  re;
    p     = model_pick(k, req);
    owner = m_grant[k];
    re    = 1'b0;
    if (m_locked[k]) begin
      if (!lock[m_master[k]]) begin
        re = 1'b1;
        m_locked[k] = 1'b0;
      end
    end else if (m_seq_left[k] > 0) begin
      if (trans == T_SEQ) begin
        if (m_seq_left[k] == 1) re = 1'b1;
        m_seq_left[k]--;
      end else if (trans != T_BUSY) begin
        re = 1'b1;
        m_seq_left[k] = 0;
      end
    end else if (trans == T_NONSEQ && lock[owner]) begin
      m_locked[k] = 1'b1;
    end else if (trans == T_NONSEQ && beats_of(burst) >= 4) begin
      m_seq_left[k] = beats_of(burst) - 1;
    end else begin
      re = 1'b1;
    end
    m_master[k] = owner;
    m_mlock[k]  = lock[owner] ? 1 : 0;
    if (re) begin
      m_grant[k] = p;
      if (req != 4'd0) m_ptr[k] = (p + 1) % N;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset(0);
      model_reset(1);
    end else if (ready) begin
      model_step(0);
      model_step(1);
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("rr_grant",  32'(grant_rr),  32'(1) << m_grant[0]);
      check("rr_master", 32'(master_rr), 32'(m_master[0]));
      check("rr_mlock",  32'(mlock_rr),  32'(m_mlock[0]));
      check("fp_grant",  32'(grant_fp),  32'(1) << m_grant[1]);
      check("fp_master", 32'(master_fp), 32'(m_master[1]));
      check("fp_mlock",  32'(mlock_fp),  32'(m_mlock[1]));
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic [1:0] t,
                      input logic [2:0] b, input logic rdy);
    req   = r;
    lock  = l;
    trans = t;
    burst = b;
    ready = rdy;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rot_exp [5];

  initial begin
    rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n = 1'b0;
    req   = 4'd0;
    lock  = 4'd0;
    trans = T_IDLE;
    burst = B_SINGLE;
    ready = 1'b1;

    // Reset values, then held with no requests.
    repeat (3) @(posedge clk);
    #1;
    check("reset_rr_grant",  32'(grant_rr),  32'h8);
    check("reset_rr_master", 32'(master_rr), 32'd3);
    check("reset_rr_mlock",  32'(mlock_rr),  32'd0);
    check("reset_fp_grant",  32'(grant_fp),  32'h4);
    check("reset_fp_master", 32'(master_fp), 32'd2);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
    check("idle_rr_grant",  32'(grant_rr),  32'h8);
    check("idle_rr_master", 32'(master_rr), 32'd3);
    check("idle_fp_grant",  32'(grant_fp),  32'h4);

    // All four request SINGLE transfers: round-robin rotates, fixed stays at 0.
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1);
      check("rotate_rr_grant", 32'(grant_rr), 32'(rot_exp[i]));
      check("rotate_fp_grant", 32'(grant_fp), 32'h1);
    end
    check("rotate_rr_master_lag", 32'(master_rr), 32'd3);

    // Master 2 INCR4, master 1 waiting: switch in the last-beat cycle.
    step(4'b0100, 4'b0000, T_IDLE,   B_SINGLE, 1'b1);
    check("pre_burst_rr_grant", 32'(grant_rr), 32'h4);
    step(4'b0110, 4'b0000, T_NONSEQ, B_INCR4,  1'b1);
    check("incr4_nonseq_grant", 32'(grant_rr), 32'h4);
    step(4'b0110, 4'b0000, T_SEQ,    B_INCR4,  1'b1);
    step(4'b0110, 4'b0000, T_SEQ,    B_INCR4,  1'b1);
    check("incr4_beat3_grant",  32'(grant_rr), 32'h4);
    step(4'b0110, 4'b0000, T_SEQ,    B_INCR4,  1'b1);
    check("incr4_last_rr_grant", 32'(grant_rr), 32'h2);
    check("incr4_last_fp_grant", 32'(grant_fp), 32'h2);

    // Same burst with 2 BUSY cycles; owner drops its request mid-burst.
    step(4'b0100, 4'b0000, T_IDLE,   B_SINGLE, 1'b1);
    step(4'b0110, 4'b0000, T_NONSEQ, B_INCR4,  1'b1);
    step(4'b0110, 4'b0000, T_SEQ,    B_INCR4,  1'b1);
    step(4'b0010, 4'b0000, T_BUSY,   B_INCR4,  1'b1);
    step(4'b0010, 4'b0000, T_BUSY,   B_INCR4,  1'b1);
    check("busy_hold_rr_grant", 32'(grant_rr), 32'h4);
    check("busy_hold_fp_grant", 32'(grant_fp), 32'h4);
    step(4'b0010, 4'b0000, T_SEQ,    B_INCR4,  1'b1);
    check("busy_beat3_grant",   32'(grant_rr), 32'h4);
    step(4'b0010, 4'b0000, T_SEQ,    B_INCR4,  1'b1);
    check("busy_last_grant",    32'(grant_rr), 32'h2);

    // Master 1 locked for 3 SINGLE transfers while master 0 requests.
    repeat (3) step(4'b0011, 4'b0010, T_NONSEQ, B_SINGLE, 1'b1);
    check("lock_rr_grant",  32'(grant_rr),  32'h2);
    check("lock_rr_master", 32'(master_rr), 32'd1);
    check("lock_rr_mlock",  32'(mlock_rr),  32'd1);
    check("lock_fp_grant",  32'(grant_fp),  32'h2);
    step(4'b0011, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
    check("unlock_rr_grant", 32'(grant_rr), 32'h1);
    check("unlock_rr_mlock", 32'(mlock_rr), 32'd0);
    check("unlock_fp_grant", 32'(grant_fp), 32'h1);

    // Request change while hready is low: nothing moves.
    repeat (5) step(4'b1000, 4'b0000, T_IDLE, B_SINGLE, 1'b0);
    check("stall_rr_grant",  32'(grant_rr),  32'h1);
    check("stall_rr_master", 32'(master_rr), 32'd1);
    check("stall_fp_grant",  32'(grant_fp),  32'h1);
    step(4'b1000, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
    check("unstall_rr_grant",  32'(grant_rr),  32'h8);
    check("unstall_rr_master", 32'(master_rr), 32'd0);

    // INCR8 ended by IDLE after beat 2.
    step(4'b1001, 4'b0000, T_NONSEQ, B_INCR8, 1'b1);
    step(4'b1001, 4'b0000, T_SEQ,    B_INCR8, 1'b1);
    check("incr8_beat2_grant", 32'(grant_rr), 32'h8);
    step(4'b1001, 4'b0000, T_IDLE,   B_INCR8, 1'b1);
    check("incr8_term_rr_grant", 32'(grant_rr), 32'h1);
    check("incr8_term_fp_grant", 32'(grant_fp), 32'h1);

    // Asynchronous reset in the middle of INCR16.
    step(4'b0100, 4'b0000, T_IDLE,   B_SINGLE, 1'b1);
    step(4'b0110, 4'b0000, T_NONSEQ, B_INCR16, 1'b1);
    step(4'b0110, 4'b0000, T_SEQ,    B_INCR16, 1'b1);
    step(4'b0110, 4'b0000, T_SEQ,    B_INCR16, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_rr_grant",  32'(grant_rr),  32'h8);
    check("midreset_rr_master", 32'(master_rr), 32'd3);
    check("midreset_rr_mlock",  32'(mlock_rr),  32'd0);
    check("midreset_fp_grant",  32'(grant_fp),  32'h4);
    check("midreset_fp_master", 32'(master_fp), 32'd2);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0010, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1);
    check("post_reset_rr_grant", 32'(grant_rr), 32'h2);
    check("post_reset_fp_grant", 32'(grant_fp), 32'h2);

    // Locked INCR4: lock outlasts the burst length.
    step(4'b0011, 4'b0010, T_NONSEQ, B_INCR4, 1'b1);
    repeat (4) step(4'b0011, 4'b0010, T_SEQ, B_INCR4, 1'b1);
    check("lock_burst_rr_grant", 32'(grant_rr), 32'h2);
    step(4'b0011, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
    check("lock_burst_release", 32'(grant_rr), 32'h1);

    // Full WRAP8 by master 0, checked by the model only.
    step(4'b0011, 4'b0000, T_NONSEQ, B_WRAP8, 1'b1);
    repeat (7) step(4'b0011, 4'b0000, T_SEQ, B_WRAP8, 1'b1);
    repeat (3) step(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
